// File: rtl/rect_pkg.sv
// rect_pkg: shared types and constants for the triple-buffer frame scheduler
package rect_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    typedef logic [1:0] idx_t;
    localparam int   NUM_BUF = 3;
    localparam idx_t WR_RST  = 2'd0;
    localparam idx_t RD_RST  = 2'd1;
    localparam idx_t RDY_RST = 2'd2;
    // The three indices always sum to NUM_BUF, so the free one is the remainder.
    function automatic idx_t third(input idx_t a, input idx_t b);
        return idx_t'(NUM_BUF) - a - b;
    endfunction
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating event counter
//   i_Sys_clk  clock
//   clr        synchronous clear, wins over inc
//   inc        count one event
//   cnt        count value, holds at all-ones
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_Sys_clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge i_Sys_clk)
        cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/rect_fbuf_sched.sv
// rect_fbuf_sched: triple-buffer scheduler between the crop/DDR writer and the display reader
//   i_Sys_clk, i_Rst_n          clock, synchronous active-low reset
//   i_Enable                    low forces IDLE and reset indices
//   i_Buffer_addr_0..2          frame buffer base addresses
//   i_Wr_frame_done             writer finished a frame
//   i_Rd_frame_start            reader begins a frame
//   i_Cnt_clr                   clear drop/repeat counters
//   o_Wr_base_addr, o_Wr_idx    buffer the writer fills next
//   o_Rd_base_addr, o_Rd_idx    buffer the reader scans
//   o_Rd_valid                  reader buffer holds a completed frame
//   o_Drop_cnt, o_Repeat_cnt    saturating statistics
module rect_fbuf_sched
    import rect_pkg::*;
#(
    parameter int AW   = 32,
    parameter int CNTW = 16
) (
    input  logic            i_Sys_clk,
    input  logic            i_Rst_n,
    input  logic            i_Enable,
    input  logic [AW-1:0]   i_Buffer_addr_0,
    input  logic [AW-1:0]   i_Buffer_addr_1,
    input  logic [AW-1:0]   i_Buffer_addr_2,
    input  logic            i_Wr_frame_done,
    input  logic            i_Rd_frame_start,
    input  logic            i_Cnt_clr,
    output logic [AW-1:0]   o_Wr_base_addr,
    output logic [AW-1:0]   o_Rd_base_addr,
    output logic            o_Rd_valid,
    output logic [1:0]      o_Wr_idx,
    output logic [1:0]      o_Rd_idx,
    output logic [CNTW-1:0] o_Drop_cnt,
    output logic [CNTW-1:0] o_Repeat_cnt
);
    state_t state, state_n;
    idx_t   wr_idx, rd_idx, rdy_idx, wr_n, rd_n, rdy_n;
    logic   rdy_valid, rdy_valid_n, rd_valid_n;
    logic   active, wr_ev, rd_ev, take, drop_inc, rep_inc;

    function automatic logic [AW-1:0] pick(input idx_t i);
        return i == 2'd2 ? i_Buffer_addr_2 : i == 2'd1 ? i_Buffer_addr_1 : i_Buffer_addr_0;
    endfunction

    always_comb begin
        active      = i_Enable && state != IDLE;
        wr_ev       = active && i_Wr_frame_done;
        rd_ev       = active && i_Rd_frame_start;
        // The reader gets a new frame either from the ready slot or, on a
        // simultaneous write completion, straight from the writer's buffer.
        take        = rd_ev && (wr_ev || rdy_valid);
        drop_inc    = wr_ev && rdy_valid;
        rep_inc     = rd_ev && !wr_ev && !rdy_valid;
        wr_n        = !i_Enable ? WR_RST : wr_ev ? third(wr_idx, rd_idx) : wr_idx;
        rd_n        = !i_Enable ? RD_RST : (take && wr_ev) ? wr_idx : take ? rdy_idx : rd_idx;
        rdy_n       = !i_Enable ? RDY_RST : take ? rd_idx : wr_ev ? wr_idx : rdy_idx;
        rdy_valid_n = !i_Enable ? 1'b0 : take ? 1'b0 : wr_ev ? 1'b1 : rdy_valid;
        rd_valid_n  = !i_Enable ? 1'b0 : take ? 1'b1 : o_Rd_valid;
        state_n     = !i_Enable ? IDLE : state == IDLE ? PRIME : take ? RUN : state;
    end

    always_ff @(posedge i_Sys_clk) begin
        if (!i_Rst_n) begin
            state          <= IDLE;
            wr_idx         <= WR_RST;
            rd_idx         <= RD_RST;
            rdy_idx        <= RDY_RST;
            rdy_valid      <= 1'b0;
            o_Rd_valid     <= 1'b0;
            o_Wr_base_addr <= i_Buffer_addr_0;
            o_Rd_base_addr <= i_Buffer_addr_1;
        end else begin
            state          <= state_n;
            wr_idx         <= wr_n;
            rd_idx         <= rd_n;
            rdy_idx        <= rdy_n;
            rdy_valid      <= rdy_valid_n;
            o_Rd_valid     <= rd_valid_n;
            o_Wr_base_addr <= pick(wr_n);
            o_Rd_base_addr <= pick(rd_n);
        end
    end

    assign o_Wr_idx = wr_idx;
    assign o_Rd_idx = rd_idx;

    sat_cnt #(.W(CNTW)) u_drop (
        .i_Sys_clk(i_Sys_clk),
        .clr      (!i_Rst_n || i_Cnt_clr),
        .inc      (drop_inc),
        .cnt      (o_Drop_cnt)
    );

    sat_cnt #(.W(CNTW)) u_repeat (
        .i_Sys_clk(i_Sys_clk),
        .clr      (!i_Rst_n || i_Cnt_clr),
        .inc      (rep_inc),
        .cnt      (o_Repeat_cnt)
    );
endmodule

// File: tb/tb_rect_fbuf_sched.sv
// tb_rect_fbuf_sched: scoreboard bench for the triple-buffer scheduler
module tb_rect_fbuf_sched;
    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h1010_0000;
    localparam logic [31:0] A2 = 32'h1020_0000;

    logic        i_Sys_clk = 1'b0;
    logic        i_Rst_n = 1'b0, i_Enable = 1'b0, i_Wr_frame_done = 1'b0, i_Rd_frame_start = 1'b0, i_Cnt_clr = 1'b0;
    logic [31:0] o_Wr_base_addr, o_Rd_base_addr;
    logic        o_Rd_valid;
    logic [1:0]  o_Wr_idx, o_Rd_idx;
    logic [15:0] o_Drop_cnt, o_Repeat_cnt;

    always #5 i_Sys_clk = ~i_Sys_clk;

    rect_fbuf_sched dut (
        .i_Sys_clk       (i_Sys_clk),
        .i_Rst_n         (i_Rst_n),
        .i_Enable        (i_Enable),
        .i_Buffer_addr_0 (A0),
        .i_Buffer_addr_1 (A1),
        .i_Buffer_addr_2 (A2),
        .i_Wr_frame_done (i_Wr_frame_done),
        .i_Rd_frame_start(i_Rd_frame_start),
        .i_Cnt_clr       (i_Cnt_clr),
        .o_Wr_base_addr  (o_Wr_base_addr),
        .o_Rd_base_addr  (o_Rd_base_addr),
        .o_Rd_valid      (o_Rd_valid),
        .o_Wr_idx        (o_Wr_idx),
        .o_Rd_idx        (o_Rd_idx),
        .o_Drop_cnt      (o_Drop_cnt),
        .o_Repeat_cnt    (o_Repeat_cnt)
    );

    typedef struct {
        logic [1:0]  w, r;
        logic        v;
        logic [15:0] d, p;
        logic [31:0] wa, ra;
    } exp_t;
    exp_t q[$];

    int errs = 0, checks = 0;
    logic perm_on = 1'b0;

    int m_st = 0, m_w = 0, m_r = 1, m_y = 2;
    logic m_yv = 1'b0, m_rv = 1'b0;
    int m_d = 0, m_p = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return i == 2 ? A2 : i == 1 ? A1 : A0;
    endfunction

    task automatic model(input logic rst_n, en, wr, rd, clr);
        bit act;
        int t;
        if (!rst_n) begin
            m_st = 0; m_w = 0; m_r = 1; m_y = 2; m_yv = 0; m_rv = 0; m_d = 0; m_p = 0;
            return;
        end
        act = en && m_st != 0;
        if (clr) begin
            m_d = 0; m_p = 0;
        end else begin
            if (act && wr && m_yv && m_d != 16'hFFFF) m_d++;
            if (act && rd && !wr && !m_yv && m_p != 16'hFFFF) m_p++;
        end
        if (!en) begin
            m_st = 0; m_w = 0; m_r = 1; m_y = 2; m_yv = 0; m_rv = 0;
        end else if (m_st == 0) m_st = 1;
        else if (wr && rd) begin
            t = m_w; m_w = 3 - m_w - m_r; m_y = m_r; m_r = t; m_yv = 0; m_rv = 1; m_st = 2;
        end else if (wr) begin
            m_y = m_w; m_yv = 1; m_w = 3 - m_w - m_r;
        end else if (rd && m_yv) begin
            t = m_r; m_r = m_y; m_y = t; m_yv = 0; m_rv = 1; m_st = 2;
        end
    endtask

    task automatic step(input logic rst_n, en, wr, rd, clr);
        exp_t e;
        i_Rst_n = rst_n; i_Enable = en; i_Wr_frame_done = wr; i_Rd_frame_start = rd; i_Cnt_clr = clr;
        model(rst_n, en, wr, rd, clr);
        e.w = 2'(m_w); e.r = 2'(m_r); e.v = m_rv; e.d = 16'(m_d); e.p = 16'(m_p);
        e.wa = addr_of(m_w); e.ra = addr_of(m_r);
        q.push_back(e);
        @(posedge i_Sys_clk);
        #1;
        e = q.pop_front();
        check("wr_idx", 64'(o_Wr_idx), 64'(e.w));
        check("rd_idx", 64'(o_Rd_idx), 64'(e.r));
        check("rd_valid", 64'(o_Rd_valid), 64'(e.v));
        check("drop", 64'(o_Drop_cnt), 64'(e.d));
        check("repeat", 64'(o_Repeat_cnt), 64'(e.p));
        check("wr_addr", 64'(o_Wr_base_addr), 64'(e.wa));
        check("rd_addr", 64'(o_Rd_base_addr), 64'(e.ra));
    endtask

    always @(negedge i_Sys_clk)
        if (perm_on)
            check("perm", 64'(o_Wr_idx != o_Rd_idx && o_Wr_idx < 2'd3 && o_Rd_idx < 2'd3), 64'd1);

    initial begin
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        perm_on = 1'b1;
        check("rst_wr_addr", 64'(o_Wr_base_addr), 64'(A0));
        check("rst_rd_addr", 64'(o_Rd_base_addr), 64'(A1));
        check("rst_valid", 64'(o_Rd_valid), 64'd0);
        check("rst_cnt", 64'({o_Drop_cnt, o_Repeat_cnt}), 64'd0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("wr1_idx", 64'(o_Wr_idx), 64'd2);
        step(1, 1, 0, 1, 0);
        check("rd1_idx", 64'(o_Rd_idx), 64'd0);
        check("rd1_addr", 64'(o_Rd_base_addr), 64'(A0));
        check("rd1_valid", 64'(o_Rd_valid), 64'd1);
        step(1, 1, 0, 1, 0);
        check("rep_idx", 64'(o_Rd_idx), 64'd0);
        check("rep_cnt", 64'(o_Repeat_cnt), 64'd1);

        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("ww_idx1", 64'(o_Wr_idx), 64'd2);
        step(1, 1, 1, 0, 0);
        check("ww_idx2", 64'(o_Wr_idx), 64'd0);
        check("ww_drop", 64'(o_Drop_cnt), 64'd1);
        step(1, 1, 0, 1, 0);
        check("ww_rd", 64'(o_Rd_idx), 64'd2);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        check("pre_sim", 64'({o_Wr_idx, o_Rd_idx}), 64'({2'd2, 2'd0}));
        step(1, 1, 1, 1, 0);
        check("sim_rd", 64'(o_Rd_idx), 64'd2);
        check("sim_wr", 64'(o_Wr_idx), 64'd1);
        check("sim_drop", 64'(o_Drop_cnt), 64'd2);
        check("sim_rep", 64'(o_Repeat_cnt), 64'd0);
        step(1, 1, 0, 1, 0);
        check("sim_nordy", 64'(o_Repeat_cnt), 64'd1);

        step(1, 0, 0, 0, 0);
        check("dis_idx", 64'({o_Wr_idx, o_Rd_idx}), 64'({2'd0, 2'd1}));
        check("dis_valid", 64'(o_Rd_valid), 64'd0);
        check("dis_cnt", 64'({o_Drop_cnt, o_Repeat_cnt}), 64'({16'd2, 16'd1}));
        step(1, 0, 1, 1, 0);
        check("idle_ign", 64'({o_Wr_idx, o_Rd_idx}), 64'({2'd0, 2'd1}));

        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 65536; i++) step(1, 1, 0, 1, 0);
        check("sat_rep", 64'(o_Repeat_cnt), 64'hFFFF);
        step(1, 1, 0, 1, 1);
        check("clr_rep", 64'(o_Repeat_cnt), 64'd0);
        check("clr_drop", 64'(o_Drop_cnt), 64'd0);

        perm_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
